// File: rtl/pipelined_ripple_adder_stage.sv
// adder_stage: combinational CHUNK-bit ripple chain of full adders.
// Reports the carry into the MSB so the last pipeline stage can form
// the signed-overflow flag without re-deriving it.
module adder_stage #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  // Bit-serial full-adder chain, carry rippling LSB to MSB
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co   = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit add/subtract split into STAGES
// registered ripple segments with a stall-all valid/ready handshake.
// Stage k resolves bits [k*CHUNK +: CHUNK]; operands and finished sum
// bits travel alongside so each beat is self-contained in the pipe.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES");
  end

  // Pipeline state; index k is the register written by stage k
  logic [STAGES:1]                 vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0]    a_r, b_r, s_r;
  logic [STAGES-1:0]               c_r;
  logic                            ovf_r;

  // Stage inputs (from the ports for stage 0, else from the previous register)
  logic [STAGES-1:0][WIDTH-1:0]    a_in, b_in, s_in, s_nxt;
  logic [STAGES-1:0]               c_in, co, cmsb;
  logic [STAGES-1:0][CHUNK-1:0]    cs;

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Subtraction folds into addition: A + ~B + ~cin == A - B - cin
  assign a_in[0] = in1;
  assign b_in[0] = sub ? ~in2 : in2;
  assign s_in[0] = '0;
  assign c_in[0] = sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k > 0) begin : g_fwd
      assign a_in[k] = a_r[k-1];
      assign b_in[k] = b_r[k-1];
      assign s_in[k] = s_r[k-1];
      assign c_in[k] = c_r[k-1];
    end

    adder_stage #(.CHUNK(CHUNK)) u_stage (
      .a    (a_in[k][k*CHUNK +: CHUNK]),
      .b    (b_in[k][k*CHUNK +: CHUNK]),
      .ci   (c_in[k]),
      .s    (cs[k]),
      .co   (co[k]),
      .cmsb (cmsb[k])
    );
  end

  // Merge each stage's chunk into the forwarded partial sum
  always_comb begin
    s_nxt = s_in;
    for (int k = 0; k < STAGES; k++) begin
      s_nxt[k][k*CHUNK +: CHUNK] = cs[k];
    end
  end

  // Whole pipe advances together or holds together (no bubble collapse)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      a_r      <= '0;
      b_r      <= '0;
      s_r      <= '0;
      c_r      <= '0;
      ovf_r    <= 1'b0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
      end
      a_r   <= a_in;
      b_r   <= b_in;
      s_r   <= s_nxt;
      c_r   <= co;
      ovf_r <= cmsb[STAGES-1] ^ co[STAGES-1];
    end
  end

  // Operand copies leaving the last stage are fully consumed
  logic unused_operands;
  assign unused_operands = ^{a_r[STAGES-1], b_r[STAGES-1]};

  assign out_valid = vld_pipe[STAGES];
  assign sum       = s_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed and randomised checks for pipelined_ripple_adder across the
// default 8/2 configuration plus 16/4 and 8/1 instances.
module tb_pipelined_ripple_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8, STAGES=2
  logic       in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 1, cout, ovf;
  logic [7:0] in1 = 0, in2 = 0, sum;

  pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // WIDTH=16, STAGES=4
  logic        w_in_valid = 0, w_in_ready, w_cin = 0, w_sub = 0, w_out_valid, w_out_ready = 1, w_cout, w_ovf;
  logic [15:0] w_in1 = 0, w_in2 = 0, w_sum;

  pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in1(w_in1), .in2(w_in2), .cin(w_cin), .sub(w_sub),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
  );

  // WIDTH=8, STAGES=1
  logic       s_in_valid = 0, s_in_ready, s_cin = 0, s_sub = 0, s_out_valid, s_out_ready = 1, s_cout, s_ovf;
  logic [7:0] s_in1 = 0, s_in2 = 0, s_sum;

  pipelined_ripple_adder #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in1(s_in1), .in2(s_in2), .cin(s_cin), .sub(s_sub),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
  );

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({ovf, cout, sum} !== 10'h000) begin errors++; $display("FAIL reset_result got %h want 000", {ovf, cout, sum}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (w_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_other_valid got %b%b want 00", w_out_valid, s_out_valid); end
    rst = 1'b0;
  endtask

  // vectors: {in1, in2, cin, sub, expected {ovf,cout,sum}}
  task automatic test_addsub;
    logic [7:0] va [8] = '{8'h05, 8'h7F, 8'h7F, 8'hFF, 8'h05, 8'h00, 8'h80, 8'h05};
    logic [7:0] vb [8] = '{8'h03, 8'h01, 8'h7F, 8'h01, 8'h03, 8'h01, 8'h01, 8'h03};
    logic       vc [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       vs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [9:0] ve [8] = '{10'h008, 10'h281, 10'h2FF, 10'h100, 10'h102, 10'h0FF, 10'h37F, 10'h101};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1; in1 = va[i]; in2 = vb[i]; cin = vc[i]; sub = vs[i];
      @(negedge clk);
      in_valid = 0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addsub_early[%0d] out_valid got %b want 0", i, out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addsub_latency[%0d] out_valid got %b want 1", i, out_valid); end
      checks++; if ({ovf, cout, sum} !== ve[i]) begin errors++; $display("FAIL addsub[%0d] {ovf,cout,sum} got %h want %h", i, {ovf, cout, sum}, ve[i]); end
    end
  endtask

  task automatic test_back_pressure;
    logic [7:0] ba [3] = '{8'h0A, 8'hF0, 8'h40};
    logic [7:0] bb [3] = '{8'h14, 8'h20, 8'h40};
    logic [9:0] be [3] = '{10'h01E, 10'h110, 10'h280};
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c < 6);
      if (sent < 3) begin
        in_valid = 1; in1 = ba[sent]; in2 = bb[sent]; cin = 0; sub = 0;
      end else in_valid = 0;
      #1;
      if (c >= 2 && c < 6) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready); end
        checks++; if (out_valid !== 1'b1 || {ovf, cout, sum} !== be[0]) begin errors++; $display("FAIL bp_hold c%0d got v=%b %h want v=1 %h", c, out_valid, {ovf, cout, sum}, be[0]); end
      end
      if (out_valid && out_ready) begin
        if (got < 3) begin
          checks++; if ({ovf, cout, sum} !== be[got]) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", got, {ovf, cout, sum}, be[got]); end
        end else begin
          errors++; $display("FAIL bp_extra beat %h got", {ovf, cout, sum});
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 0; out_ready = 1;
    checks++; if (got != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got); end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk); in_valid = 1; in1 = 8'h01; in2 = 8'h02; cin = 0; sub = 0;
    @(negedge clk); in1 = 8'h03; in2 = 8'h04;
    @(negedge clk); in_valid = 0; rst = 1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    checks++; if ({ovf, cout, sum} !== 10'h000) begin errors++; $display("FAIL rst_mid_result got %h want 000", {ovf, cout, sum}); end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale[%0d] out_valid got %b want 0", i, out_valid); end
    end
    in_valid = 1; in1 = 8'h11; in2 = 8'h22;
    @(negedge clk); in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_next_early got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || {ovf, cout, sum} !== 10'h033) begin errors++; $display("FAIL rst_next got v=%b %h want v=1 033", out_valid, {ovf, cout, sum}); end
  endtask

  task automatic test_sweep_w16;
    logic [17:0] q [$];
    int          qc [$];
    logic [17:0] e;
    int          at, sa, sb, sv, uv;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (w_out_valid) begin
        if (q.size() == 0) begin
          errors++; $display("FAIL w16_spurious got %h", {w_ovf, w_cout, w_sum});
        end else begin
          e = q.pop_front(); at = qc.pop_front();
          checks++; if ({w_ovf, w_cout, w_sum} !== e) begin errors++; $display("FAIL w16_result got %h want %h", {w_ovf, w_cout, w_sum}, e); end
          checks++; if (cyc - at != 4) begin errors++; $display("FAIL w16_latency got %0d want 4", cyc - at); end
        end
      end
      w_in_valid = (i < 56) && ($urandom_range(0, 3) != 0);
      w_in1 = 16'($urandom); w_in2 = 16'($urandom); w_cin = 1'($urandom); w_sub = 1'($urandom);
      if (i < 4) begin w_in1 = 16'h8000; w_in2 = 16'h0000; w_cin = 1; w_sub = 1; w_in_valid = 1; end
      if (w_in_valid) begin
        sa = int'($signed(w_in1)); sb = int'($signed(w_in2));
        sv = w_sub ? sa - sb - int'(w_cin) : sa + sb + int'(w_cin);
        uv = w_sub ? int'(w_in1) - int'(w_in2) - int'(w_cin) : int'(w_in1) + int'(w_in2) + int'(w_cin);
        e  = {(sv > 32767 || sv < -32768), (w_sub ? (uv >= 0) : uv[16]), uv[15:0]};
        q.push_back(e); qc.push_back(cyc);
      end
    end
    w_in_valid = 0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL w16_lost got %0d pending want 0", q.size()); end
  endtask

  task automatic test_sweep_s1;
    logic [9:0] q [$];
    int         qc [$];
    logic [9:0] e;
    int         at, sa, sb, sv, uv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_out_valid) begin
        if (q.size() == 0) begin
          errors++; $display("FAIL s1_spurious got %h", {s_ovf, s_cout, s_sum});
        end else begin
          e = q.pop_front(); at = qc.pop_front();
          checks++; if ({s_ovf, s_cout, s_sum} !== e) begin errors++; $display("FAIL s1_result got %h want %h", {s_ovf, s_cout, s_sum}, e); end
          checks++; if (cyc - at != 1) begin errors++; $display("FAIL s1_latency got %0d want 1", cyc - at); end
        end
      end
      s_in_valid = (i < 44) && ($urandom_range(0, 3) != 0);
      s_in1 = 8'($urandom); s_in2 = 8'($urandom); s_cin = 1'($urandom); s_sub = 1'($urandom);
      if (s_in_valid) begin
        sa = int'($signed(s_in1)); sb = int'($signed(s_in2));
        sv = s_sub ? sa - sb - int'(s_cin) : sa + sb + int'(s_cin);
        uv = s_sub ? int'(s_in1) - int'(s_in2) - int'(s_cin) : int'(s_in1) + int'(s_in2) + int'(s_cin);
        e  = {(sv > 127 || sv < -128), (s_sub ? (uv >= 0) : uv[8]), uv[7:0]};
        q.push_back(e); qc.push_back(cyc);
      end
    end
    s_in_valid = 0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL s1_lost got %0d pending want 0", q.size()); end
  endtask

  initial begin
    test_reset;
    test_addsub;
    test_back_pressure;
    test_reset_midflight;
    test_sweep_w16;
    test_sweep_s1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
